// File: rtl/mem_arbiter_if.sv
// Operation encoding and the bundled requester/memory bus of the two-port memory arbiter.
// slave is the arbiter side; master is the side driving requests and memory responses.
package mem_arbiter_pkg;
    typedef enum logic [3:0] {
        LOAD_STORE_NONE    = 4'd0,
        LOAD_BYTE          = 4'd1,
        LOAD_HALF          = 4'd2,
        LOAD_WORD          = 4'd3,
        LOAD_BYTE_UNSIGNED = 4'd4,
        LOAD_HALF_UNSIGNED = 4'd5,
        STORE_BYTE         = 4'd6,
        STORE_HALF         = 4'd7,
        STORE_WORD         = 4'd8
    } mem_op_t;
endpackage

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_data;
    logic        if_fault;

    logic        dm_req;
    mem_op_t     dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_fault;

    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_ack, if_data, if_fault, dm_ack, dm_rdata, dm_fault,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_ack, if_data, if_fault, dm_ack, dm_rdata, dm_fault,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, with data priority
// bounded by a starvation counter, lane formatting for loads/stores and misalignment faults.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state,      w_state;
    logic          r_owner_data, w_owner_data;
    mem_op_t       r_op,         w_op;
    logic [1:0]    r_lane,       w_lane;
    logic [CW-1:0] r_starve,     w_starve;
    logic          r_mem_valid,  w_mem_valid;
    logic          r_mem_we,     w_mem_we;
    logic [31:0]   r_mem_addr,   w_mem_addr;
    logic [31:0]   r_mem_wdata,  w_mem_wdata;
    logic [3:0]    r_mem_wstrb,  w_mem_wstrb;
    logic          r_if_ack,     w_if_ack;
    logic          r_dm_ack,     w_dm_ack;
    logic          r_if_fault,   w_if_fault;
    logic          r_dm_fault,   w_dm_fault;
    logic [31:0]   r_if_data,    w_if_data;
    logic [31:0]   r_dm_rdata,   w_dm_rdata;

    logic          w_grant_fetch;
    mem_op_t       w_sel_op;
    logic [31:0]   w_sel_addr;
    logic          w_misalign;
    logic          w_none;
    logic          w_store;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;

    // Selects and extends the addressed lane of a memory read word.
    function automatic logic [31:0] load_fmt(mem_op_t op, logic [1:0] lane, logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (op)
            LOAD_BYTE:          return {{24{b[7]}}, b};
            LOAD_BYTE_UNSIGNED: return {24'd0, b};
            LOAD_HALF:          return {{16{h[15]}}, h};
            LOAD_HALF_UNSIGNED: return {16'd0, h};
            LOAD_WORD:          return d;
            default:            return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_op         <= LOAD_STORE_NONE;
            r_lane       <= 2'd0;
            r_starve     <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wstrb  <= 4'd0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_fault   <= 1'b0;
            r_dm_fault   <= 1'b0;
            r_if_data    <= 32'd0;
            r_dm_rdata   <= 32'd0;
        end else begin
            r_state      <= w_state;
            r_owner_data <= w_owner_data;
            r_op         <= w_op;
            r_lane       <= w_lane;
            r_starve     <= w_starve;
            r_mem_valid  <= w_mem_valid;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_mem_wstrb  <= w_mem_wstrb;
            r_if_ack     <= w_if_ack;
            r_dm_ack     <= w_dm_ack;
            r_if_fault   <= w_if_fault;
            r_dm_fault   <= w_dm_fault;
            r_if_data    <= w_if_data;
            r_dm_rdata   <= w_dm_rdata;
        end
    end

    // Next state and next registered outputs; request decode happens on the would-be winner.
    always_comb begin
        w_state      = r_state;
        w_owner_data = r_owner_data;
        w_op         = r_op;
        w_lane       = r_lane;
        w_starve     = r_starve;
        w_mem_valid  = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_wstrb  = 4'd0;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_if_ack     = 1'b0;
        w_dm_ack     = 1'b0;
        w_if_fault   = 1'b0;
        w_dm_fault   = 1'b0;
        w_if_data    = r_if_data;
        w_dm_rdata   = r_dm_rdata;

        w_grant_fetch = bus.if_req && (!bus.dm_req || (r_starve == CW'(STARVE_MAX)));
        w_sel_op      = w_grant_fetch ? LOAD_WORD : bus.dm_op;
        w_sel_addr    = w_grant_fetch ? bus.if_addr : bus.dm_addr;
        w_load        = load_fmt(r_op, r_lane, bus.mem_rdata);

        w_misalign = 1'b0;
        w_none     = 1'b0;
        w_store    = 1'b0;
        w_strb     = 4'd0;
        w_wdata    = bus.dm_wdata;
        case (w_sel_op)
            LOAD_BYTE, LOAD_BYTE_UNSIGNED: ;
            LOAD_HALF, LOAD_HALF_UNSIGNED: w_misalign = w_sel_addr[0];
            LOAD_WORD:  w_misalign = |w_sel_addr[1:0];
            STORE_BYTE: begin
                w_store = 1'b1;
                w_strb  = 4'b0001 << w_sel_addr[1:0];
                w_wdata = {4{bus.dm_wdata[7:0]}};
            end
            STORE_HALF: begin
                w_misalign = w_sel_addr[0];
                w_store    = 1'b1;
                w_strb     = w_sel_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.dm_wdata[15:0]}};
            end
            STORE_WORD: begin
                w_misalign = |w_sel_addr[1:0];
                w_store    = 1'b1;
                w_strb     = 4'b1111;
            end
            default: w_none = 1'b1;
        endcase

        case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_owner_data = !w_grant_fetch;
                    w_op         = w_sel_op;
                    w_lane       = w_sel_addr[1:0];
                    if (w_grant_fetch)
                        w_starve = '0;
                    else if (bus.if_req)
                        w_starve = r_starve + CW'(1);
                    if (w_none || w_misalign) begin
                        w_state    = S_DONE;
                        w_if_ack   = w_grant_fetch;
                        w_dm_ack   = !w_grant_fetch;
                        w_if_fault = w_grant_fetch && w_misalign;
                        w_dm_fault = !w_grant_fetch && w_misalign;
                        if (w_grant_fetch) w_if_data  = 32'd0;
                        else               w_dm_rdata = 32'd0;
                    end else begin
                        w_state     = S_BUSY;
                        w_mem_valid = 1'b1;
                        w_mem_we    = w_store;
                        w_mem_wstrb = w_strb;
                        w_mem_addr  = {w_sel_addr[31:2], 2'b00};
                        w_mem_wdata = w_wdata;
                    end
                end
            end
            S_BUSY: begin
                if (bus.mem_ready) begin
                    w_state  = S_DONE;
                    w_if_ack = !r_owner_data;
                    w_dm_ack = r_owner_data;
                    if (r_owner_data) w_dm_rdata = w_load;
                    else              w_if_data  = w_load;
                end else begin
                    w_mem_valid = 1'b1;
                    w_mem_we    = r_mem_we;
                    w_mem_wstrb = r_mem_wstrb;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_data   = r_if_data;
    assign bus.if_fault  = r_if_fault;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_fault  = r_dm_fault;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts grant order, memory
// traffic and responses; monitors compare acks and accepted memory beats against queues.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned STARVE_MAX = 4;

    typedef struct {
        bit          fetch;
        bit          fault;
        bit          chk;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  wstrb;
        bit          chk_wdata;
        logic [31:0] wdata;
    } mem_t;

    logic clk;
    logic reset;
    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;
    int vcycles = 0;
    int mode = 0;          // 0: ready tied high, 1: random ready, 2: ready held low
    int starve_m = 0;
    bit f_pend = 0, d_pend = 0;
    logic [31:0] f_addr, d_addr, d_wdata;
    mem_op_t d_op;
    resp_t rq[$];
    mem_t  mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a single granted request should do, from the access rules.
    task automatic model(input bit f, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output resp_t r, output mem_t m, output bit skip);
        int size = 0;
        bit st = 0, sgn = 0;
        logic [31:0] v;
        mem_op_t eop = f ? LOAD_WORD : op;
        case (eop)
            LOAD_BYTE:          begin size = 1; sgn = 1; end
            LOAD_BYTE_UNSIGNED: size = 1;
            LOAD_HALF:          begin size = 2; sgn = 1; end
            LOAD_HALF_UNSIGNED: size = 2;
            LOAD_WORD:          size = 4;
            STORE_BYTE:         begin size = 1; st = 1; end
            STORE_HALF:         begin size = 2; st = 1; end
            STORE_WORD:         begin size = 4; st = 1; end
            default:            size = 0;
        endcase
        r.fetch = f; r.fault = 0; r.chk = 1; r.data = 32'd0;
        m.addr = 32'd0; m.we = 0; m.wstrb = 4'd0; m.chk_wdata = 0; m.wdata = 32'd0;
        skip = 1;
        if (size == 0) begin
        end else if ((size == 4 && a[1:0] != 2'd0) || (size == 2 && a[0])) begin
            r.fault = 1;
        end else begin
            skip = 0;
            m.addr = a & ~32'h3;
            m.we = st;
            if (st) begin
                r.chk = 0;
                m.chk_wdata = 1;
                m.wstrb = 4'(((1 << size) - 1) << a[1:0]);
                m.wdata = (size == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
                          (size == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
            end else begin
                v = rd >> (8 * a[1:0]);
                if (size == 1)      v = sgn ? 32'($signed(v[7:0]))  : {24'd0, v[7:0]};
                else if (size == 2) v = sgn ? 32'($signed(v[15:0])) : {16'd0, v[15:0]};
                r.data = v;
            end
        end
    endtask

    task automatic drive_fetch(input logic [31:0] a);
        f_addr = a; f_pend = 1;
        bus.if_addr = a; bus.if_req = 1'b1;
    endtask

    task automatic drive_data(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd);
        d_op = op; d_addr = a; d_wdata = wd; d_pend = 1;
        bus.dm_op = op; bus.dm_addr = a; bus.dm_wdata = wd; bus.dm_req = 1'b1;
    endtask

    // Predict the winner of the pending requests, queue expectations, wait for its ack.
    task automatic serve(input logic [31:0] rd, output int lat, output bit skip);
        resp_t r;
        mem_t  m;
        bit win_f = f_pend && (!d_pend || starve_m == int'(STARVE_MAX));
        if (win_f)       starve_m = 0;
        else if (f_pend) starve_m++;
        model(win_f, d_op, win_f ? f_addr : d_addr, d_wdata, rd, r, m, skip);
        bus.mem_rdata = rd;
        rq.push_back(r);
        if (!skip) mq.push_back(m);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (win_f ? bus.if_ack : bus.dm_ack) break;
            if (lat > 60) begin
                checks++; errors++;
                $display("FAIL ack_timeout: no ack after %0d cycles (fetch=%0d)", lat, win_f);
                break;
            end
        end
        if (skip)           chk("latency_skip", 32'(lat), 32'd2);
        else if (mode == 0) chk("latency_zero_wait", 32'(lat), 32'd3);
        else begin
            checks++;
            if (lat < 3) begin errors++; $display("FAIL latency_min: got %0d expected >= 3", lat); end
        end
        @(posedge clk); #1;
        if (win_f) begin f_pend = 0; bus.if_req = 1'b0; end
        else       begin d_pend = 0; bus.dm_req = 1'b0; end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // Memory responder: ready pattern selected by mode.
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.mem_ready = 1'b1;
            2:       bus.mem_ready = 1'b0;
            default: bus.mem_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: acks against the response queue, accepted beats against the memory queue.
    always @(negedge clk) begin
        resp_t r;
        mem_t  m;
        if (!reset) begin
            if (bus.mem_valid) vcycles++;
            if (bus.if_ack || bus.dm_ack) begin
                ack_seen++;
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: if_ack=%0d dm_ack=%0d", bus.if_ack, bus.dm_ack);
                end else begin
                    r = rq.pop_front();
                    chk("ack_owner_fetch", 32'(bus.if_ack), 32'(r.fetch));
                    chk("ack_owner_data", 32'(bus.dm_ack), 32'(!r.fetch));
                    chk("ack_fault", 32'(r.fetch ? bus.if_fault : bus.dm_fault), 32'(r.fault));
                    if (r.chk) chk("ack_data", r.fetch ? bus.if_data : bus.dm_rdata, r.data);
                end
            end
            if (!bus.if_ack) chk("if_fault_outside_ack", 32'(bus.if_fault), 32'd0);
            if (!bus.dm_ack) chk("dm_fault_outside_ack", 32'(bus.dm_fault), 32'd0);
            if (bus.mem_valid && bus.mem_ready) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_beat: addr=0x%08h", bus.mem_addr);
                end else begin
                    m = mq.pop_front();
                    chk("mem_addr", bus.mem_addr, m.addr);
                    chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m.wstrb));
                    if (m.chk_wdata) chk("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, v0, a0;
        bit skip;
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_op = LOAD_STORE_NONE;
        bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_ready = 1'b1; bus.mem_rdata = 0;
        d_op = LOAD_STORE_NONE; d_addr = 0; d_wdata = 0; f_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 0);
        chk("rst_if_ack", 32'(bus.if_ack), 0);
        chk("rst_dm_ack", 32'(bus.dm_ack), 0);
        chk("rst_if_fault", 32'(bus.if_fault), 0);
        chk("rst_dm_fault", 32'(bus.dm_fault), 0);
        chk("rst_if_data", bus.if_data, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed accesses with zero-wait memory.
        v0 = vcycles;
        drive_fetch(32'h10); serve(32'h13, lat, skip);
        chk("fetch_valid_cycles", 32'(vcycles - v0), 32'd1);
        chk("if_data_holds", bus.if_data, 32'h13);
        drive_data(STORE_BYTE, 32'h403, 32'hA5); serve($urandom, lat, skip);
        drive_data(LOAD_HALF, 32'h402, 32'h0); serve(32'h8001FFFF, lat, skip);
        drive_data(LOAD_HALF_UNSIGNED, 32'h402, 32'h0); serve(32'h8001FFFF, lat, skip);
        chk("dm_rdata_holds", bus.dm_rdata, 32'h00008001);
        v0 = vcycles;
        drive_data(LOAD_WORD, 32'h402, 32'h0); serve($urandom, lat, skip);
        drive_data(STORE_HALF, 32'h401, 32'h1234); serve($urandom, lat, skip);
        drive_fetch(32'h22); serve($urandom, lat, skip);
        chk("misaligned_no_valid", 32'(vcycles - v0), 32'd0);
        drive_data(LOAD_STORE_NONE, 32'h0, 32'h0); serve($urandom, lat, skip);
        drive_data(STORE_WORD, 32'h1000, 32'hDEADBEEF); serve($urandom, lat, skip);
        drive_data(LOAD_BYTE, 32'h1003, 32'h0); serve(32'h80FF7F01, lat, skip);

        // Both requesters continuously busy: starvation bound governs the order.
        for (int i = 0; i < 20; i++) begin
            if (!f_pend) drive_fetch({$urandom_range(0, 1023), 2'b00});
            if (!d_pend) drive_data(mem_op_t'(4'($urandom_range(1, 8))), rand_addr(), $urandom);
            serve($urandom, lat, skip);
        end

        // Random traffic with random memory wait states.
        mode = 1;
        for (int i = 0; i < 300; i++) begin
            if (!f_pend && $urandom_range(0, 2) != 0) drive_fetch(rand_addr());
            if (!d_pend && $urandom_range(0, 2) != 0)
                drive_data(mem_op_t'(4'($urandom_range(0, 8))), rand_addr(), $urandom);
            if (f_pend || d_pend) serve($urandom, lat, skip);
            else begin @(posedge clk); #1; end
        end
        while (f_pend || d_pend) serve($urandom, lat, skip);

        // Reset while the memory stalls a request in flight.
        mode = 2;
        @(posedge clk); #1;
        drive_data(LOAD_WORD, 32'h100, 32'h0);
        for (int k = 0; k < 10 && !bus.mem_valid; k++) @(negedge clk);
        chk("busy_before_reset", 32'(bus.mem_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; bus.dm_req = 1'b0; d_pend = 0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_drops_valid", 32'(bus.mem_valid), 32'd0);
        chk("reset_no_ack", 32'(bus.dm_ack), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; starve_m = 0; mode = 0;
        a0 = ack_seen;
        repeat (10) @(negedge clk);
        chk("no_ack_after_reset", 32'(ack_seen - a0), 32'd0);
        @(posedge clk); #1;
        drive_fetch(32'h40); serve(32'hCAFEF00D, lat, skip);

        repeat (4) @(posedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("mem_queue_empty", 32'(mq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
